// File: rtl/i2c_eeprom_master_pkg.sv
// Shared encodings for the I2C EEPROM initiator: FSM states, R/W bit, quarter phases,
// and the per-state pad drive table.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_START  = 4'd1,
    ST_DEV_W  = 4'd2,
    ST_ACK_D  = 4'd3,
    ST_ADDR   = 4'd4,
    ST_ACK_A  = 4'd5,
    ST_WDATA  = 4'd6,
    ST_ACK_W  = 4'd7,
    ST_RSTART = 4'd8,
    ST_DEV_R  = 4'd9,
    ST_ACK_R  = 4'd10,
    ST_RDATA  = 4'd11,
    ST_MNACK  = 4'd12,
    ST_STOP   = 4'd13
  } state_e;

  localparam logic I2C_WR = 1'b0;
  localparam logic I2C_RD = 1'b1;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // Returns {scl_oe, sda_oe} for a state and quarter; tx_bit is the bit on the wire.
  function automatic logic [1:0] bus_drive(input state_e st, input logic [1:0] q,
                                           input logic tx_bit);
    logic scl_low;
    scl_low = (q == Q0) || (q == Q3);
    case (st)
      ST_IDLE:              bus_drive = 2'b00;
      ST_START, ST_RSTART:  bus_drive = {q == Q3, (q == Q2) || (q == Q3)};
      ST_STOP:              bus_drive = {q == Q0, (q == Q0) || (q == Q1)};
      ST_DEV_W, ST_ADDR, ST_WDATA, ST_DEV_R:
                            bus_drive = {scl_low, ~tx_bit};
      default:              bus_drive = {scl_low, 1'b0};
    endcase
  endfunction

  function automatic state_e after_byte(input state_e st);
    case (st)
      ST_DEV_W: after_byte = ST_ACK_D;
      ST_ADDR:  after_byte = ST_ACK_A;
      ST_WDATA: after_byte = ST_ACK_W;
      ST_DEV_R: after_byte = ST_ACK_R;
      ST_RDATA: after_byte = ST_MNACK;
      default:  after_byte = ST_STOP;
    endcase
  endfunction

endpackage

// File: rtl/i2c_eeprom_master_if.sv
// Command handshake, status and open-drain pad controls of the I2C EEPROM initiator.
interface i2c_eeprom_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [6:0] cmd_dev;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       done;
  logic       ack_err;
  logic [7:0] rd_data;
  logic       busy;
  logic       scl_oe;
  logic       sda_oe;
  logic       sda_in;

  modport master (
    input  cmd_valid, cmd_rw, cmd_dev, cmd_addr, cmd_wdata, sda_in,
    output cmd_ready, done, ack_err, rd_data, busy, scl_oe, sda_oe
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_dev, cmd_addr, cmd_wdata, sda_in,
    input  cmd_ready, done, ack_err, rd_data, busy, scl_oe, sda_oe
  );
endinterface

// File: rtl/i2c_eeprom_master_qtick.sv
// Quarter-bit timebase: CLK_DIV divider plus a free-wrapping 2-bit quarter index.
module i2c_qtick
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic       clr_i,
  output logic       tick_o,
  output logic [1:0] q_o
);

  localparam logic [15:0] TC = 16'(CLK_DIV - 1);

  logic [15:0] cnt_q;
  logic [1:0]  q_q;

  assign tick_o = en_i && (cnt_q == TC);
  assign q_o    = q_q;

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      cnt_q <= '0;
      q_q   <= Q0;
    end else if (tick_o) begin
      cnt_q <= '0;
      q_q   <= q_q + 2'd1;
    end else if (en_i) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/i2c_eeprom_master.sv
// Single-byte random write / read I2C initiator for an EEPROM slave.
// state   | meaning
// IDLE    | ready for a command; also hosts the one-cycle done pulse
// START   | START condition;  RSTART | repeated START before the read
// DEV_W   | device address + W;  DEV_R | device address + R
// ADDR    | word address;  WDATA | write byte;  RDATA | read byte
// ACK_*   | slave ACK slot;  MNACK | master NACK closing the read
// STOP    | STOP condition, then done
module i2c_eeprom_master
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 125
) (
  input logic              clk,
  input logic              reset,
  i2c_eeprom_master_if.master bus
);

  state_e     state_q;
  logic       cmd_rw_q;
  logic [6:0] cmd_dev_q;
  logic [7:0] cmd_addr_q;
  logic [7:0] cmd_wdata_q;
  logic [7:0] sh_q;
  logic [2:0] bit_q;
  logic       ack_q;
  logic       err_q;
  logic       busy_q;
  logic       done_q;
  logic       ack_err_q;
  logic [7:0] rd_data_q;
  logic       cmd_ready_q;
  logic       scl_oe_q;
  logic       sda_oe_q;

  logic       tick;
  logic [1:0] q;
  logic       accept;
  logic [1:0] drv_d;

  assign accept = bus.cmd_valid && cmd_ready_q;
  assign drv_d  = bus_drive(state_q, q, sh_q[7]);

  i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clk    (clk),
    .reset  (reset),
    .en_i   (busy_q),
    .clr_i  (accept),
    .tick_o (tick),
    .q_o    (q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_rw_q    <= I2C_WR;
      cmd_dev_q   <= '0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      sh_q        <= '0;
      bit_q       <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_err_q   <= 1'b0;
      rd_data_q   <= '0;
      cmd_ready_q <= 1'b1;
      scl_oe_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
    end else begin
      scl_oe_q <= drv_d[1];
      sda_oe_q <= drv_d[0];
      if (state_q == ST_IDLE) begin
        done_q    <= 1'b0;
        ack_err_q <= 1'b0;
        if (done_q) begin
          cmd_ready_q <= 1'b1;
        end else if (accept) begin
          cmd_rw_q    <= bus.cmd_rw;
          cmd_dev_q   <= bus.cmd_dev;
          cmd_addr_q  <= bus.cmd_addr;
          cmd_wdata_q <= bus.cmd_wdata;
          err_q       <= 1'b0;
          busy_q      <= 1'b1;
          cmd_ready_q <= 1'b0;
          state_q     <= ST_START;
        end
      end else if (tick) begin
        if (q == Q2) begin
          ack_q <= bus.sda_in;
          if (state_q == ST_RDATA) sh_q <= {sh_q[6:0], bus.sda_in};
        end
        if (q == Q3) begin
          case (state_q)
            ST_START: begin
              state_q <= ST_DEV_W;
              sh_q    <= {cmd_dev_q, I2C_WR};
              bit_q   <= '0;
            end
            ST_DEV_W, ST_ADDR, ST_WDATA, ST_DEV_R, ST_RDATA: begin
              bit_q <= bit_q + 3'd1;
              if (state_q != ST_RDATA) sh_q <= {sh_q[6:0], 1'b0};
              if (bit_q == 3'd7) state_q <= after_byte(state_q);
            end
            ST_ACK_D: begin
              if (ack_q) begin
                err_q   <= 1'b1;
                state_q <= ST_STOP;
              end else begin
                state_q <= ST_ADDR;
                sh_q    <= cmd_addr_q;
                bit_q   <= '0;
              end
            end
            ST_ACK_A: begin
              if (ack_q) begin
                err_q   <= 1'b1;
                state_q <= ST_STOP;
              end else if (cmd_rw_q == I2C_RD) begin
                state_q <= ST_RSTART;
              end else begin
                state_q <= ST_WDATA;
                sh_q    <= cmd_wdata_q;
                bit_q   <= '0;
              end
            end
            ST_ACK_W: begin
              err_q   <= ack_q;
              state_q <= ST_STOP;
            end
            ST_RSTART: begin
              state_q <= ST_DEV_R;
              sh_q    <= {cmd_dev_q, I2C_RD};
              bit_q   <= '0;
            end
            ST_ACK_R: begin
              if (ack_q) begin
                err_q   <= 1'b1;
                state_q <= ST_STOP;
              end else begin
                state_q <= ST_RDATA;
                bit_q   <= '0;
              end
            end
            ST_MNACK: state_q <= ST_STOP;
            ST_STOP: begin
              // cmd_ready stays low through the done cycle; it rises one clk later
              state_q   <= ST_IDLE;
              done_q    <= 1'b1;
              busy_q    <= 1'b0;
              ack_err_q <= err_q;
              if (!err_q && (cmd_rw_q == I2C_RD)) rd_data_q <= sh_q;
            end
            default: state_q <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.done      = done_q;
  assign bus.ack_err   = ack_err_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.busy      = busy_q;
  assign bus.scl_oe    = scl_oe_q;
  assign bus.sda_oe    = sda_oe_q;

endmodule
